fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage for the B32P pipeline. It replaces the
//  fixed single-cycle FE stage and talks to instruction memory of variable
//  latency over a req/ack handshake. Fetched words are queued with their PC+STEP
//  in a small prefetch FIFO, which the DE stage drains under hold. A jump/branch
//  redirect from MEM flushes the FIFO and restarts fetch at jump_addr.
// PARAMETERS
//  ADDR_W     32  width of PC and bus address
//  DATA_W     32  instruction width
//  FIFO_DEPTH 4   prefetch entries; power of two, >=2
//  RESET_PC   0   first fetch address after reset
//  PC_STEP    4   PC increment per instruction
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-high reset
//  jump         in   1       redirect request (jump/branch taken/halt in MEM)
//  jump_addr    in   ADDR_W  redirect target, valid when jump=1
//  hold         in   1       DE stall; head entry is not consumed
//  bus_req      out  1       fetch request to instruction memory
//  bus_addr     out  ADDR_W  fetch address, stable while bus_req=1 and no ack
//  bus_ack      in   1       memory returns bus_q for current request
//  bus_q        in   DATA_W  fetched instruction, valid when bus_ack=1
//  instr        out  DATA_W  FIFO head instruction to DE
//  pc4          out  ADDR_W  FIFO head PC+PC_STEP to DE
//  instr_valid  out  1       FIFO head valid
//  fifo_count   out  $clog2(FIFO_DEPTH+1)  occupied entries (debug/perf)
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, FIFO empty, state IDLE, bus_req=0,
//    bus_addr=RESET_PC, instr=0, pc4=0, instr_valid=0, fifo_count=0. An
//    assertion mid-transaction drops bus_req immediately; memory tolerates
//    an abandoned request.
//  - At most one outstanding request. bus_req/bus_addr are registered.
//  - States: IDLE (no request), REQ (bus_req=1, waiting ack), DISCARD (bus_req=1
//    on a stale address; data dropped on ack).
//  - IDLE->REQ when count+pending_push < FIFO_DEPTH; bus_addr<=fetch_pc.
//  - REQ on ack: push {bus_q, bus_addr+PC_STEP}; fetch_pc+=PC_STEP. If space
//    remains (counting this cycle's pop), stay REQ with the next address.
//    Otherwise go IDLE. With zero-wait memory (ack in the cycle req is high),
//    throughput is 1 instr/cycle.
//  - Consume: pop = instr_valid & ~hold & ~jump. Push and pop can happen in the
//    same cycle at full or empty. The pushed word is visible on instr the cycle
//    after ack (no bypass).
//  - jump has priority over hold, ack and pop: the FIFO is cleared and
//    fetch_pc<=jump_addr. instr_valid=0 in the next cycle.
//      REQ, no ack this cycle -> DISCARD (keep old bus_addr until ack).
//      REQ with ack this cycle -> data dropped; next cycle REQ at jump_addr.
//      IDLE -> REQ at jump_addr next cycle.
//      DISCARD, jump again -> target updated, stay DISCARD.
//  - DISCARD on ack: no push; -> REQ at fetch_pc next cycle.
//  - PC arithmetic is modulo 2^ADDR_W; wrap from max to 0 is legal, no flag.
//  - fifo_count never exceeds FIFO_DEPTH. A push into a full FIFO cannot occur
//    by construction; the bench asserts this.
// STRUCTURE
//  - fetch_defs.vh (shared include): state localparams IDLE/REQ/DISCARD and
//    the default PC_STEP.
//  - Sub-module fetch_fifo: parametrised sync FIFO (WIDTH, DEPTH), show-ahead
//    head, push/pop/clear, count out, async reset. Instantiated once with
//    WIDTH=DATA_W+ADDR_W.
//  - Top level holds the FSM, fetch_pc and request-space accounting.
// TESTING
//  1 Zero-wait memory (ack same cycle as req), hold=0 -> after reset,
//    instr_valid from cycle 3; pc4 = 4,8,12,... once per cycle.
//  2 3-cycle memory latency, hold=1 throughout -> exactly FIFO_DEPTH(4) acks;
//    bus_req then low, fifo_count=4. Release hold -> the 4 entries drain in
//    order and fetch resumes at 0x10.
//  3 jump=1 to 0x100 while a request to 0x8 is waiting for ack -> bus_addr stays
//    0x8 until ack; 0x8 data never appears; next request is 0x100; first valid
//    pc4=0x104.
//  4 jump coincident with ack and hold=1 -> FIFO empty next cycle, ack data
//    dropped, bus_addr=jump_addr next cycle.
//  5 Two jumps (0x200, then 0x300) during DISCARD -> only fetches from 0x300
//    onward are delivered.
//  6 RESET_PC=0xFFFFFFF8, zero-wait memory -> pc4 sequence 0xFFFFFFFC, 0x0,
//    0x4. Reset asserted mid-REQ -> bus_req=0 in the same cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared state type and defaults for the B32P instruction-fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam int unsigned DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with show-ahead head, clear and occupancy count.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// B32P fetch stage: one-outstanding req/ack fetch FSM feeding a prefetch FIFO,
// flushed and redirected by jumps from MEM.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              jump,
    input  logic [ADDR_W-1:0]                 jump_addr,
    input  logic                              hold,
    output logic                              bus_req,
    output logic [ADDR_W-1:0]                 bus_addr,
    input  logic                              bus_ack,
    input  logic [DATA_W-1:0]                 bus_q,
    output logic [DATA_W-1:0]                 instr,
    output logic [ADDR_W-1:0]                 pc4,
    output logic                              instr_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int unsigned       CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_req_q, bus_req_d;
    logic              push, pop;
    logic [CW-1:0]     count_after;
    logic [ADDR_W-1:0] next_pc;
    logic [DATA_W+ADDR_W-1:0] head;

    assign pop         = instr_valid && !hold && !jump;
    assign count_after = fifo_count + CW'(1) - CW'(pop);

    // While a request is live, fetch_pc equals bus_addr; a jump only retargets fetch_pc.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        bus_addr_d = bus_addr_q;
        bus_req_d  = bus_req_q;
        push       = 1'b0;
        next_pc    = jump ? jump_addr : fetch_pc_q;
        case (state_q)
            ST_IDLE: begin
                fetch_pc_d = next_pc;
                if (jump || (fifo_count < DEPTH_C)) begin
                    state_d    = ST_REQ;
                    bus_req_d  = 1'b1;
                    bus_addr_d = next_pc;
                end
            end
            ST_REQ: begin
                if (jump) begin
                    fetch_pc_d = jump_addr;
                    if (bus_ack) begin
                        bus_addr_d = jump_addr;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end else if (bus_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + STEP;
                    if (count_after < DEPTH_C) begin
                        bus_addr_d = fetch_pc_q + STEP;
                    end else begin
                        state_d   = ST_IDLE;
                        bus_req_d = 1'b0;
                    end
                end
            end
            ST_DISCARD: begin
                fetch_pc_d = next_pc;
                if (bus_ack) begin
                    state_d    = ST_REQ;
                    bus_addr_d = next_pc;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            bus_addr_q <= RESET_PC;
            bus_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            bus_addr_q <= bus_addr_d;
            bus_req_q  <= bus_req_d;
        end
    end

    fetch_fifo #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (jump),
        .push       (push),
        .push_data  ({bus_q, bus_addr_q + STEP}),
        .pop        (pop),
        .head_data  (head),
        .head_valid (instr_valid),
        .count      (fifo_count)
    );

    assign bus_req  = bus_req_q;
    assign bus_addr = bus_addr_q;
    assign instr    = head[DATA_W+ADDR_W-1:ADDR_W];
    assign pc4      = head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stream checked against an "instructions arrive in program order" model.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, jump, hold;
    logic [31:0] jump_addr;
    logic        bus_req, bus_ack;
    logic [31:0] bus_addr, bus_q, instr, pc4;
    logic        instr_valid;
    logic [2:0]  fifo_count;

    logic        rst_w, tie0, ack_w, bus_req_w, instr_valid_w;
    logic [31:0] zero32, q_w, bus_addr_w, instr_w, pc4_w;
    logic [2:0]  fifo_count_w;

    int          mem_lat   = 0;
    int          wait_cnt  = 0;
    logic        mem_ready = 1'b0;
    logic [31:0] salt      = 32'h0;
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a, input logic [31:0] s);
        return {a[15:0], ~a[31:16]} ^ s;
    endfunction

    // Instruction memory: ack after mem_lat wait cycles, gated by mem_ready.
    assign bus_ack = bus_req && mem_ready && (wait_cnt >= mem_lat);
    assign bus_q   = mem_data(bus_addr, salt);
    always @(posedge clk) wait_cnt <= (!bus_req || bus_ack) ? 0 : wait_cnt + 1;

    assign tie0   = 1'b0;
    assign zero32 = 32'h0;
    assign ack_w  = bus_req_w;
    assign q_w    = mem_data(bus_addr_w, salt);

    fetch_unit dut (
        .clk(clk), .reset(reset), .jump(jump), .jump_addr(jump_addr), .hold(hold),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_q(bus_q),
        .instr(instr), .pc4(pc4), .instr_valid(instr_valid), .fifo_count(fifo_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(rst_w), .jump(tie0), .jump_addr(zero32), .hold(tie0),
        .bus_req(bus_req_w), .bus_addr(bus_addr_w), .bus_ack(ack_w), .bus_q(q_w),
        .instr(instr_w), .pc4(pc4_w), .instr_valid(instr_valid_w), .fifo_count(fifo_count_w)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input logic hld, input logic rdy);
        reset = 1'b1; jump = 1'b0; hold = hld; mem_lat = lat; mem_ready = rdy;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bus_req: got %b expected 0", bus_req); end
        vectors++; if (bus_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_bus_addr: got %h expected 0", bus_addr); end
        vectors++; if (instr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
        vectors++; if (pc4 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc4: got %h expected 0", pc4); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
        vectors++; if (bus_addr_w !== 32'hFFFF_FFF8) begin miscompares++; $display("[TB] FAIL reset_wrap_addr: got %h expected fffffff8", bus_addr_w); end
    endtask

    task automatic test_zero_wait;
        do_reset(0, 1'b0, 1'b1);
        tick;
        vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL zw_first_req: got req=%b addr=%h expected req=1 addr=0", bus_req, bus_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL zw_early_valid: got %b expected 0", instr_valid); end
        for (int k = 0; k < 10; k++) begin
            tick;
            vectors++;
            if (instr_valid !== 1'b1 || pc4 !== 32'(4 * (k + 1)) || instr !== mem_data(32'(4 * k), salt)) begin
                miscompares++;
                $display("[TB] FAIL zw_stream[%0d]: got v=%b pc4=%h instr=%h expected v=1 pc4=%h instr=%h",
                         k, instr_valid, pc4, instr, 32'(4 * (k + 1)), mem_data(32'(4 * k), salt));
            end
        end
    endtask

    task automatic test_hold_fill;
        int  acks = 0;
        int  n = 0;
        bit  seen = 0;
        do_reset(3, 1'b1, 1'b1);
        for (int c = 0; c < 60; c++) begin
            if (bus_ack) acks++;
            tick;
        end
        vectors++; if (acks != 4) begin miscompares++; $display("[TB] FAIL fill_acks: got %0d expected 4", acks); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_req_low: got %b expected 0", bus_req); end
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("[TB] FAIL fill_count: got %0d expected 4", fifo_count); end
        hold = 1'b0;
        for (int c = 0; c < 80 && n < 6; c++) begin
            if (bus_req && !seen) begin
                seen = 1;
                vectors++; if (bus_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL fill_resume_addr: got %h expected 10", bus_addr); end
            end
            if (instr_valid) begin
                vectors++;
                if (pc4 !== 32'(4 * (n + 1)) || instr !== mem_data(32'(4 * n), salt)) begin
                    miscompares++;
                    $display("[TB] FAIL fill_drain[%0d]: got pc4=%h instr=%h expected pc4=%h", n, pc4, instr, 32'(4 * (n + 1)));
                end
                n++;
            end
            if (n < 6) tick;
        end
        vectors++; if (n != 6 || !seen) begin miscompares++; $display("[TB] FAIL fill_timeout: got pops=%0d resumed=%0d expected 6 and 1", n, seen); end
    endtask

    task automatic test_jump_pending;
        bit found = 0;
        do_reset(0, 1'b1, 1'b1);
        for (int c = 0; c < 20 && !found; c++) begin
            if (bus_req && bus_addr == 32'h8) begin found = 1; mem_ready = 1'b0; end
            else tick;
        end
        vectors++; if (!found) begin miscompares++; $display("[TB] FAIL jp_reach_8: got none expected request at 8"); end
        tick; tick;
        jump = 1'b1; jump_addr = 32'h100;
        tick;
        jump = 1'b0;
        vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h8) begin miscompares++; $display("[TB] FAIL jp_keep_addr: got req=%b addr=%h expected req=1 addr=8", bus_req, bus_addr); end
        vectors++; if (instr_valid !== 1'b0 || fifo_count !== 3'd0) begin miscompares++; $display("[TB] FAIL jp_flush: got v=%b cnt=%0d expected 0 0", instr_valid, fifo_count); end
        tick;
        vectors++; if (bus_addr !== 32'h8) begin miscompares++; $display("[TB] FAIL jp_keep_addr2: got %h expected 8", bus_addr); end
        mem_ready = 1'b1; hold = 1'b0;
        tick;
        vectors++; if (bus_addr !== 32'h100 || instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL jp_retarget: got addr=%h v=%b expected 100 0", bus_addr, instr_valid); end
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (instr_valid) found = 1; else tick;
        end
        vectors++;
        if (!found || pc4 !== 32'h104 || instr !== mem_data(32'h100, salt)) begin
            miscompares++; $display("[TB] FAIL jp_first_valid: got found=%0d pc4=%h expected 1 104", found, pc4);
        end
    endtask

    task automatic test_jump_with_ack;
        bit found = 0;
        do_reset(2, 1'b1, 1'b1);
        for (int c = 0; c < 40 && !found; c++) begin
            if (bus_ack && fifo_count >= 3'd1) found = 1; else tick;
        end
        vectors++; if (!found) begin miscompares++; $display("[TB] FAIL ja_setup: got none expected ack with data queued"); end
        jump = 1'b1; jump_addr = 32'h400;
        tick;
        jump = 1'b0;
        vectors++; if (fifo_count !== 3'd0 || instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ja_flush: got cnt=%0d v=%b expected 0 0", fifo_count, instr_valid); end
        vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin miscompares++; $display("[TB] FAIL ja_addr: got req=%b addr=%h expected 1 400", bus_req, bus_addr); end
        hold = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (instr_valid) found = 1; else tick;
        end
        vectors++;
        if (!found || pc4 !== 32'h404 || instr !== mem_data(32'h400, salt)) begin
            miscompares++; $display("[TB] FAIL ja_first_valid: got found=%0d pc4=%h expected 1 404", found, pc4);
        end
    endtask

    task automatic test_double_jump;
        int n = 0;
        do_reset(0, 1'b0, 1'b0);
        tick;
        jump = 1'b1; jump_addr = 32'h200;
        tick;
        jump_addr = 32'h300;
        tick;
        jump = 1'b0;
        vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL dj_stale_addr: got req=%b addr=%h expected 1 0", bus_req, bus_addr); end
        mem_ready = 1'b1;
        tick;
        vectors++; if (bus_addr !== 32'h300) begin miscompares++; $display("[TB] FAIL dj_target: got %h expected 300", bus_addr); end
        for (int c = 0; c < 30 && n < 4; c++) begin
            if (instr_valid) begin
                vectors++;
                if (pc4 !== 32'h304 + 32'(4 * n)) begin miscompares++; $display("[TB] FAIL dj_stream[%0d]: got %h expected %h", n, pc4, 32'h304 + 32'(4 * n)); end
                n++;
            end
            if (n < 4) tick;
        end
        vectors++; if (n != 4) begin miscompares++; $display("[TB] FAIL dj_timeout: got %0d expected 4", n); end
    endtask

    task automatic test_wrap_and_reset;
        logic [31:0] exp_pc4 [3];
        logic [31:0] exp_ins [3];
        exp_pc4 = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        exp_ins = '{mem_data(32'hFFFF_FFF8, salt), mem_data(32'hFFFF_FFFC, salt), mem_data(32'h0, salt)};
        rst_w = 1'b0;
        tick; tick;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (instr_valid_w !== 1'b1 || pc4_w !== exp_pc4[k] || instr_w !== exp_ins[k]) begin
                miscompares++; $display("[TB] FAIL wrap[%0d]: got v=%b pc4=%h expected 1 %h", k, instr_valid_w, pc4_w, exp_pc4[k]);
            end
            tick;
        end
        do_reset(0, 1'b0, 1'b0);
        tick;
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("[TB] FAIL midreq_setup: got %b expected 1", bus_req); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL midreq_reset: got req=%b addr=%h expected 0 0", bus_req, bus_addr); end
        tick;
        reset = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] exp_addr = 32'h0;
        logic [31:0] prev_addr = 32'h0;
        bit          prev_wait = 0;
        int          pops = 0;
        do_reset(0, 1'b0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            vectors++; if (bus_req && fifo_count >= 3'd4) begin miscompares++; $display("[TB] FAIL rnd_space[%0d]: got req with cnt=%0d expected cnt<4", c, fifo_count); end
            vectors++; if (instr_valid !== (fifo_count != 3'd0)) begin miscompares++; $display("[TB] FAIL rnd_valid[%0d]: got v=%b cnt=%0d", c, instr_valid, fifo_count); end
            if (prev_wait) begin
                vectors++; if (bus_addr !== prev_addr) begin miscompares++; $display("[TB] FAIL rnd_addr_stable[%0d]: got %h expected %h", c, bus_addr, prev_addr); end
            end
            if (instr_valid) begin
                vectors++;
                if (pc4 !== exp_addr + 32'h4 || instr !== mem_data(exp_addr, salt)) begin
                    miscompares++; $display("[TB] FAIL rnd_stream[%0d]: got pc4=%h instr=%h expected pc4=%h instr=%h",
                                            c, pc4, instr, exp_addr + 32'h4, mem_data(exp_addr, salt));
                end
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            hold      = ($urandom_range(0, 3) == 0);
            jump      = ($urandom_range(0, 29) == 0);
            jump_addr = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                                    : ($urandom() & 32'hFFFF_FFFC);
            #0;
            prev_wait = bus_req && !bus_ack;
            prev_addr = bus_addr;
            if (jump) exp_addr = jump_addr;
            else if (instr_valid && !hold) begin exp_addr = exp_addr + 32'h4; pops++; end
            tick;
        end
        jump = 1'b0; hold = 1'b0;
        vectors++; if (pops < 300) begin miscompares++; $display("[TB] FAIL rnd_progress: got %0d pops expected at least 300", pops); end
    endtask

    initial begin
        reset = 1'b1; rst_w = 1'b1; jump = 1'b0; hold = 1'b0; jump_addr = 32'h0;
        mem_ready = 1'b1; mem_lat = 0;
        salt = $urandom();
        test_reset;
        test_zero_wait;
        test_hold_fill;
        test_jump_pending;
        test_jump_with_ack;
        test_double_jump;
        test_wrap_and_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
